sc_sobol_sng_serial: RTL and testbench

//  Bit-serial stochastic number generator: the transmit end of the SC stream path, feeding

---
 rtl/sc_sobol_sng_serial.sv | 146 ++++++++++++++
 tb/tb_sc_sobol_sng_serial.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sc_sobol_sng_serial.sv
// Bit-serial Sobol stochastic number generator with valid/ready operand intake and framed stream output.
// Optional macro SC_SNG_DUAL_EN adds a second operand compared against Sobol dimension 2.
module sc_sobol_sng_serial #(
  parameter int SEQ_WIDTH     = 4,
  parameter int STREAM_LENGTH = 2 ** SEQ_WIDTH,
  parameter int DATA_WIDTH    = SEQ_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic                  sc_valid,
  input  logic                  sc_ready,
  output logic                  sc_a_bit,
  output logic                  sc_b_bit,
  output logic                  sc_first,
  output logic                  sc_last
);

  // state  | meaning
  // IDLE   | waiting for an operand, in_ready high
  // STREAM | emitting beats n = 0..STREAM_LENGTH-1
  typedef enum logic {S_IDLE, S_STREAM} state_t;

  localparam logic [SEQ_WIDTH-1:0] LAST_N = SEQ_WIDTH'(STREAM_LENGTH - 1);

  state_t                state_q, state_d;
  logic [SEQ_WIDTH-1:0]  n_q, n_d;
  logic [SEQ_WIDTH-1:0]  x1_q, x1_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic                  streaming, last_xfer, accept, advance;

  // Direction vector selected by the lowest zero bit of n (trailing-ones count).
  function automatic logic [SEQ_WIDTH-1:0] dir_v1(input logic [SEQ_WIDTH-1:0] n);
    logic [SEQ_WIDTH-1:0] v;
    logic                 run;
    v   = '0;
    run = 1'b1;
    for (int i = 0; i < SEQ_WIDTH; i++) begin
      if (run && !n[i]) begin
        v[SEQ_WIDTH-1-i] = 1'b1;
        run              = 1'b0;
      end
    end
    return v;
  endfunction

  always_comb begin
    streaming = (state_q == S_STREAM);
    last_xfer = streaming && (n_q == LAST_N) && sc_ready;
    in_ready  = !streaming || last_xfer;
    accept    = in_valid && in_ready;
    advance   = streaming && sc_ready && !last_xfer;

    state_d = state_q;
    n_d     = n_q;
    x1_d    = x1_q;
    a_d     = a_q;
    if (accept) begin
      state_d = S_STREAM;
      n_d     = '0;
      x1_d    = '0;
      a_d     = a_in;
    end else if (last_xfer) begin
      state_d = S_IDLE;
    end else if (advance) begin
      n_d  = n_q + 1'b1;
      x1_d = x1_q ^ dir_v1(n_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      x1_q    <= '0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      x1_q    <= x1_d;
      a_q     <= a_d;
    end
  end

  assign sc_valid = streaming;
  assign sc_first = streaming && (n_q == '0);
  assign sc_last  = streaming && (n_q == LAST_N);
  assign sc_a_bit = streaming && (a_q > DATA_WIDTH'(x1_q));

`ifdef SC_SNG_DUAL_EN
  logic [SEQ_WIDTH-1:0]  x2_q, x2_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;

  // Dimension 2 (polynomial x+1): v[k] = v[k-1] ^ (v[k-1] >> 1), starting at the MSB.
  function automatic logic [SEQ_WIDTH-1:0] dir_v2(input logic [SEQ_WIDTH-1:0] n);
    logic [SEQ_WIDTH-1:0] v, r;
    logic                 run;
    v              = '0;
    v[SEQ_WIDTH-1] = 1'b1;
    r              = '0;
    run            = 1'b1;
    for (int i = 0; i < SEQ_WIDTH; i++) begin
      if (run) begin
        if (!n[i]) begin
          r   = v;
          run = 1'b0;
        end else begin
          v = v ^ (v >> 1);
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    x2_d = x2_q;
    b_d  = b_q;
    if (accept) begin
      x2_d = '0;
      b_d  = b_in;
    end else if (advance) begin
      x2_d = x2_q ^ dir_v2(n_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x2_q <= '0;
      b_q  <= '0;
    end else begin
      x2_q <= x2_d;
      b_q  <= b_d;
    end
  end

  assign sc_b_bit = streaming && (b_q > DATA_WIDTH'(x2_q));
`else
  logic unused_b_in;
  assign unused_b_in = ^b_in;
  assign sc_b_bit    = 1'b0;
`endif

endmodule

// File: tb/tb_sc_sobol_sng_serial.sv
// Self-checking bench for sc_sobol_sng_serial: directed and randomized streams against a Gray-code Sobol model.
module tb_sc_sobol_sng_serial;
  localparam int SW = 4;
  localparam int L  = 16;
  localparam int DW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] a_in = '0;
  logic [DW-1:0] b_in = '0;
  logic          sc_valid;
  logic          sc_ready = 1'b0;
  logic          sc_a_bit, sc_b_bit, sc_first, sc_last;

  int n_cmp = 0;
  int n_err = 0;

  sc_sobol_sng_serial #(.SEQ_WIDTH(SW), .STREAM_LENGTH(L), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .sc_valid(sc_valid), .sc_ready(sc_ready),
    .sc_a_bit(sc_a_bit), .sc_b_bit(sc_b_bit), .sc_first(sc_first), .sc_last(sc_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Dimension 1 Sobol point n = bit-reversed Gray code of n.
  function automatic int sob1(input int n);
    int g, r;
    g = n ^ (n >> 1);
    r = 0;
    for (int j = 0; j < SW; j++) if (g[j]) r |= 1 << (SW - 1 - j);
    return r;
  endfunction

  // Dimension 2 Sobol point: XOR of direction numbers m = 1,3,5,15 selected by Gray code bits.
  function automatic int sob2(input int n);
    int g, r;
    int m[4] = '{1, 3, 5, 15};
    g = n ^ (n >> 1);
    r = 0;
    for (int j = 0; j < SW; j++) if (g[j]) r ^= m[j] << (SW - 1 - j);
    return r;
  endfunction

  function automatic int exp_b(input int b, input int n);
`ifdef SC_SNG_DUAL_EN
    return (b > sob2(n)) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic int min_l(input int v);
    return (v > L) ? L : v;
  endfunction

  task automatic start(input int a, input int b);
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = DW'(a);
    b_in     = DW'(b);
    sc_ready = 1'b0;
    #1;
    check("start_in_ready", in_ready, 1);
    check("start_sc_valid", sc_valid, 0);
    @(posedge clk);
  endtask

  // Consumes one whole stream, checking every sampled beat against the model.
  task automatic do_stream(input int a, input int b, input int stall_pct, input bit chain,
                           input int na, input int nb, input bit noise, output int and_cnt);
    int beat, cyc, ones, b_ones;
    bit rdy;
    logic abit, bbit;
    beat = 0; cyc = 0; ones = 0; b_ones = 0; and_cnt = 0;
    while (beat < L && cyc < 400) begin
      @(negedge clk);
      rdy      = ($urandom_range(99) >= stall_pct);
      sc_ready = rdy;
      if (beat == L - 1) begin
        in_valid = chain;
        a_in     = DW'(na);
        b_in     = DW'(nb);
      end else if (noise) begin
        in_valid = 1'($urandom_range(1));
        a_in     = DW'($urandom);
        b_in     = DW'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      abit = sc_a_bit;
      bbit = sc_b_bit;
      check("beat_valid", sc_valid, 1);
      check("beat_a_bit", abit, (a > sob1(beat)) ? 1 : 0);
      check("beat_b_bit", bbit, exp_b(b, beat));
      check("beat_first", sc_first, (beat == 0) ? 1 : 0);
      check("beat_last", sc_last, (beat == L - 1) ? 1 : 0);
      check("beat_in_ready", in_ready, (beat == L - 1 && rdy) ? 1 : 0);
      @(posedge clk);
      if (rdy) begin
        ones    += int'(abit);
        b_ones  += int'(bbit);
        and_cnt += int'(abit & bbit);
        beat++;
      end
      cyc++;
    end
    check("stream_budget", beat, L);
    check("stream_ones_a", ones, min_l(a));
`ifdef SC_SNG_DUAL_EN
    check("stream_ones_b", b_ones, min_l(b));
`else
    check("stream_ones_b", b_ones, 0);
`endif
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    sc_ready = 1'b1;
    #1;
    check({tag, "_valid"}, sc_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_first"}, sc_first, 0);
    check({tag, "_last"}, sc_last, 0);
  endtask

  initial begin
    int ac;
    int ra, rb;
    #2;
    check("rst_valid", sc_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_a_bit", sc_a_bit, 0);
    check("rst_b_bit", sc_b_bit, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Half-scale operand, full throughput.
    start(8, 8);
    do_stream(8, 8, 0, 1'b0, 0, 0, 1'b0, ac);
`ifdef SC_SNG_DUAL_EN
    check("dual_and_8_8", ac, 4);
`endif
    expect_idle("idle_after_8");

    // Boundaries: zero, full scale, saturated.
    start(0, 0);
    do_stream(0, 0, 0, 1'b0, 0, 0, 1'b0, ac);
    expect_idle("idle_after_0");
    start(16, 7);
    do_stream(16, 7, 0, 1'b0, 0, 0, 1'b0, ac);
`ifdef SC_SNG_DUAL_EN
    check("dual_and_16_7", ac, 7);
`endif
    expect_idle("idle_after_16");
    start(31, 31);
    do_stream(31, 31, 0, 1'b0, 0, 0, 1'b0, ac);
    expect_idle("idle_after_31");

    // Back-to-back with no bubble.
    start(5, 3);
    do_stream(5, 3, 0, 1'b1, 11, 9, 1'b0, ac);
    do_stream(11, 9, 0, 1'b0, 0, 0, 1'b0, ac);
    expect_idle("idle_after_b2b");

    // Backpressure with ignored in_valid noise mid-stream.
    start(13, 6);
    do_stream(13, 6, 50, 1'b0, 0, 0, 1'b1, ac);
    expect_idle("idle_after_bp");

    // Randomized operands, stall rates and chaining.
    ra = $urandom_range(31);
    rb = $urandom_range(31);
    start(ra, rb);
    for (int k = 0; k < 6; k++) begin
      int na, nb;
      bit ch;
      na = $urandom_range(31);
      nb = $urandom_range(31);
      ch = (k < 5) ? 1'($urandom_range(1)) : 1'b0;
      do_stream(ra, rb, $urandom_range(60), ch, na, nb, 1'($urandom_range(1)), ac);
      if (ch) begin
        ra = na;
        rb = nb;
      end else begin
        expect_idle("idle_rand");
        if (k < 5) begin
          ra = $urandom_range(31);
          rb = $urandom_range(31);
          start(ra, rb);
        end
      end
    end

    // Asynchronous reset mid-stream.
    start(12, 12);
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b0;
      sc_ready = 1'b1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", sc_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_a_bit", sc_a_bit, 0);
    check("arst_first", sc_first, 0);
    check("arst_last", sc_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_idle("idle_after_arst");
    start(8, 8);
    do_stream(8, 8, 25, 1'b0, 0, 0, 1'b0, ac);
    expect_idle("idle_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
